// File: rtl/window_send_engine.sv
`default_nettype none
// ============================================================================
// Module      : window_send_engine
// Description : Streams a captured window of N_WORDS pixel words out over a
//               valid/ready interface. On a send request the whole window is
//               snapshotted into a shadow register. Words are then presented
//               one beat at a time, with out_last on the final word. A
//               one-cycle send_done pulse follows the last handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W     pixel word width in bits
//   N_WORDS    words per window transfer (1..255)
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   send_req   level request, held until send_done is seen
//   win_data   window to send; word k at [k*DATA_W +: DATA_W]
//   out_ready  downstream ready
//   out_data   current output word
//   out_valid  out_data valid
//   out_last   final word of the transfer (qualified by out_valid)
//   send_done  one-cycle completion pulse
//   busy       high in STREAM or DONE
//   stall_cnt  (only with WINDOW_SEND_STALL_CNT_EN) saturating count of
//              cycles with out_valid=1 and out_ready=0
// Build option
//   `define WINDOW_SEND_STALL_CNT_EN adds the stall_cnt port and its counter
// ============================================================================
module window_send_engine #(
   parameter int DATA_W  = 8,
   parameter int N_WORDS = 9
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      send_req,
   input  logic [N_WORDS*DATA_W-1:0] win_data,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_valid,
   output logic                      out_last,
   output logic                      send_done,
   output logic                      busy
`ifdef WINDOW_SEND_STALL_CNT_EN
   ,
   output logic [15:0]               stall_cnt
`endif
);

   localparam int               CNT_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                    state_q;
   logic [N_WORDS*DATA_W-1:0] shadow_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [CNT_W-1:0]          cnt_d;
   logic [DATA_W-1:0]         next_word_d;
   logic [DATA_W-1:0]         out_data_q;
   logic                      out_valid_q;
   logic                      out_last_q;
   logic                      send_done_q;
   logic                      busy_q;

   // Index and word of the beat that follows the current one. These are
   // only consumed on a non-last handshake, so cnt_d never exceeds LAST_IDX
   // where it matters.
   always_comb begin
      cnt_d       = cnt_q + 1'b1;
      next_word_d = shadow_q[cnt_d*DATA_W +: DATA_W];
   end

   // All outputs are registered. The next word is loaded into out_data_q at
   // the handshake edge, so out_data always equals shadow word[cnt_q] while
   // streaming.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         shadow_q    <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         send_done_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               send_done_q <= 1'b0;
               if (send_req) begin
                  // The first word comes straight from win_data, which
                  // gives a one-cycle request-to-valid latency.
                  shadow_q    <= win_data;
                  cnt_q       <= '0;
                  out_data_q  <= win_data[DATA_W-1:0];
                  out_valid_q <= 1'b1;
                  out_last_q  <= (LAST_IDX == '0);
                  busy_q      <= 1'b1;
                  state_q     <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (out_ready) begin
                  if (cnt_q == LAST_IDX) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     send_done_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     cnt_q      <= cnt_d;
                     out_data_q <= next_word_d;
                     out_last_q <= (cnt_d == LAST_IDX);
                  end
               end
            end
            S_DONE: begin
               // One-cycle completion; send_req is deliberately ignored here
               // so a still-high request cannot retrigger a capture.
               send_done_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: begin
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
               send_done_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign send_done = send_done_q;
   assign busy      = busy_q;

`ifdef WINDOW_SEND_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_send_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_send_engine
// Description : Scoreboard bench for window_send_engine. Stimulus pushes the
//               expected beats and completion pulses into queues. A monitor
//               pops and compares them on every handshake and send_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_send_engine;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic        send_req;
   logic [71:0] win_data;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic        send_done;
   logic        busy;

   logic        s1_req;
   logic [7:0]  s1_win;
   logic        s1_ready;
   logic [7:0]  s1_data;
   logic        s1_valid;
   logic        s1_last;
   logic        s1_done;
   logic        s1_busy;

`ifdef WINDOW_SEND_STALL_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] s1_stall_cnt;
`endif

   int    n_vec = 0;
   int    n_err = 0;
   beat_t exp_q[$];
   int    exp_done = 0;

   window_send_engine #(.DATA_W(8), .N_WORDS(9)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .send_req  (send_req),
      .win_data  (win_data),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .send_done (send_done),
      .busy      (busy)
`ifdef WINDOW_SEND_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   window_send_engine #(.DATA_W(8), .N_WORDS(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .send_req  (s1_req),
      .win_data  (s1_win),
      .out_ready (s1_ready),
      .out_data  (s1_data),
      .out_valid (s1_valid),
      .out_last  (s1_last),
      .send_done (s1_done),
      .busy      (s1_busy)
`ifdef WINDOW_SEND_STALL_CNT_EN
      ,
      .stall_cnt (s1_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every handshake and every completion pulse of the
   // 9-word instance against the scoreboard queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("beat_expected", 32'd0, 32'd1);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
               chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
            end
         end
         if (send_done) begin
            chk("done_expected", {31'd0, (exp_done > 0)}, 32'd1);
            if (exp_done > 0) exp_done--;
         end
      end
   end

   task automatic push_window(input logic [71:0] win);
      for (int k = 0; k < 9; k++) begin
         beat_t b;
         b.data = win[k*8 +: 8];
         b.last = (k == 8);
         exp_q.push_back(b);
      end
      exp_done++;
   endtask

   // One 9-word transfer. Cycle c is the c-th cycle after the capture edge.
   // out_ready is low for cycles slo..shi. In cycle done_cyc+1 the request
   // either drops or (keep=1) stays high with next_win presented. chained=1
   // means the request was already left high by the previous call.
   task automatic xfer(input logic [71:0] win, input int slo, input int shi,
                       input int done_cyc, input bit keep, input logic [71:0] next_win,
                       input bit chained, input int corrupt_cyc);
      push_window(win);
      if (!chained) begin
         @(posedge clk); #1;
         win_data  = win;
         send_req  = 1'b1;
         out_ready = 1'b1;
      end
      for (int c = 1; c <= done_cyc + 1; c++) begin
         @(posedge clk); #1;
         out_ready = !(c >= slo && c <= shi);
         if (c == corrupt_cyc) win_data = '1;
         if (c == done_cyc + 1) begin
            send_req = keep;
            if (keep) win_data = next_win;
         end
         @(negedge clk);
         if (c == 1) chk("first_valid", {31'd0, out_valid}, 32'd1);
         if (c >= slo && c <= shi) chk("valid_held", {31'd0, out_valid}, 32'd1);
         if (c == done_cyc) begin
            chk("done_pulse", {31'd0, send_done}, 32'd1);
            chk("done_no_valid", {31'd0, out_valid}, 32'd0);
            chk("done_busy", {31'd0, busy}, 32'd1);
         end
         if (c == done_cyc - 1) chk("last_flag", {31'd0, out_last}, 32'd1);
         if (c == done_cyc + 1) begin
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_done", {31'd0, send_done}, 32'd0);
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      send_req  = 1'b0;
      win_data  = '0;
      out_ready = 1'b0;
      s1_req    = 1'b0;
      s1_win    = '0;
      s1_ready  = 1'b1;

      // Reset state, checked before any clock edge
      #3;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_last",  {31'd0, out_last},  32'd0);
      chk("rst_done",  {31'd0, send_done}, 32'd0);
      chk("rst_busy",  {31'd0, busy},      32'd0);
      chk("rst_data",  {24'd0, out_data},  32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Nominal transfer, words 0x10..0x18
      xfer(72'h18_17_16_15_14_13_12_11_10, 0, -1, 10, 1'b0, '0, 1'b0, 0);

      // Back-pressure during cycles 3-5
      xfer(72'h18_17_16_15_14_13_12_11_10, 3, 5, 13, 1'b0, '0, 1'b0, 0);
`ifdef WINDOW_SEND_STALL_CNT_EN
      chk("stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif

      // Request held through DONE, then a second window captured in IDLE
      xfer(72'h99_88_77_66_55_44_33_22_11, 0, -1, 10, 1'b1,
           72'h0F_0E_0D_0C_0B_0A_09_08_07, 1'b0, 0);
      xfer(72'h0F_0E_0D_0C_0B_0A_09_08_07, 0, -1, 10, 1'b0, '0, 1'b1, 0);

      // win_data overwritten with all-ones mid-transfer
      xfer(72'hC9_B8_A7_96_85_74_63_52_41, 0, -1, 10, 1'b0, '0, 1'b0, 4);

      // Reset during beat 4
      push_window(72'h99_88_77_66_55_44_33_22_11);
      @(posedge clk); #1;
      win_data  = 72'h99_88_77_66_55_44_33_22_11;
      send_req  = 1'b1;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_busy",  {31'd0, busy},      32'd0);
      chk("arst_done",  {31'd0, send_done}, 32'd0);
      exp_q.delete();
      exp_done = 0;
      send_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
`ifdef WINDOW_SEND_STALL_CNT_EN
      chk("stall_cnt_rst", {16'd0, stall_cnt}, 32'd0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("no_resume", {31'd0, out_valid}, 32'd0);
      xfer(72'h0F_0E_0D_0C_0B_0A_09_08_07, 0, -1, 10, 1'b0, '0, 1'b0, 0);

      // Single-word instance
      @(posedge clk); #1;
      s1_win = 8'hAB;
      s1_req = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("n1_valid", {31'd0, s1_valid}, 32'd1);
      chk("n1_data",  {24'd0, s1_data},  32'h0000_00AB);
      chk("n1_last",  {31'd0, s1_last},  32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("n1_done",  {31'd0, s1_done},  32'd1);
      chk("n1_nvalid", {31'd0, s1_valid}, 32'd0);
      @(posedge clk); #1;
      s1_req = 1'b0;
      @(negedge clk);
      chk("n1_idle",  {31'd0, s1_busy},  32'd0);

      repeat (2) @(posedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("done_drained", exp_done, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
